alu_issue_ctrl: RTL and testbench

//  Instruction issue/sequencing front end for the 16-bit ALU. Accepts one 16-bit instruction per

---
 rtl/alu_issue_ctrl.sv | 184 ++++++++++++++++++
 tb/tb_alu_issue_ctrl.sv | 290 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_issue_ctrl.sv
// Issue/sequencing front end for the 16-bit ALU: accepts one instruction per handshake,
// decodes it against the internal register file, and retires the ALU result and flags.
module alu_issue_ctrl #(
    parameter int NREGS = 16,
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             instr_valid,
    output logic             instr_ready,
    input  logic [15:0]      instr,
    output logic [7:0]       alu_opcode,
    output logic [WIDTH-1:0] alu_a,
    output logic [WIDTH-1:0] alu_b,
    output logic             alu_carry_in,
    input  logic [WIDTH-1:0] alu_c,
    input  logic [4:0]       alu_flags,
    output logic [4:0]       psr,
    output logic             done,
    output logic             illegal,
    input  logic [3:0]       dbg_addr,
    output logic [WIDTH-1:0] dbg_data
);

    typedef enum logic [1:0] {
        IDLE,
        DECODE,
        EXEC,
        WB
    } state_t;

    state_t           state;
    logic [15:0]      instr_q;
    logic [WIDTH-1:0] regs [NREGS];
    logic [WIDTH-1:0] result;
    logic [4:0]       flag_q;
    logic             wb_en;
    logic             psr_en;
    logic             illegal_q;

    logic [3:0]       op;
    logic [3:0]       opext;
    logic [3:0]       rdest;
    logic [3:0]       rsrc;
    logic [7:0]       imm8;

    logic [7:0]       dec_opcode;
    logic [WIDTH-1:0] dec_b;
    logic             dec_wb;
    logic             dec_psr;
    logic             dec_legal;

    assign op    = instr_q[15:12];
    assign rdest = instr_q[11:8];
    assign opext = instr_q[7:4];
    assign rsrc  = instr_q[3:0];
    assign imm8  = instr_q[7:0];

    assign instr_ready = (state == IDLE);
    assign dbg_data    = regs[dbg_addr];

    // Decode of the latched instruction; only sampled while in DECODE.
    always_comb begin
        dec_opcode = '0;
        dec_b      = '0;
        dec_wb     = 1'b0;
        dec_psr    = 1'b0;
        dec_legal  = 1'b1;
        case (op)
            4'h0: begin
                dec_opcode = {4'h0, opext};
                dec_b      = regs[rsrc];
                case (opext)
                    4'h1, 4'h2, 4'h3, 4'hF: dec_wb = 1'b1;
                    4'h4, 4'h5, 4'h6, 4'h7, 4'h9: begin
                        dec_wb  = 1'b1;
                        dec_psr = 1'b1;
                    end
                    4'h8, 4'hB: dec_psr = 1'b1;
                    default: dec_legal = 1'b0;
                endcase
            end
            4'h8: begin
                dec_opcode = {4'h8, opext};
                dec_wb     = 1'b1;
                case (opext)
                    4'h4, 4'h5, 4'h6, 4'h7: dec_b = regs[rsrc];
                    4'h0, 4'h1: dec_b = {{(WIDTH-4){1'b0}}, rsrc};
                    default: dec_legal = 1'b0;
                endcase
            end
            4'h5, 4'h9, 4'h7: begin
                dec_opcode = {op, 4'h0};
                dec_b      = {{(WIDTH-8){imm8[7]}}, imm8};
                dec_wb     = 1'b1;
                dec_psr    = 1'b1;
            end
            4'hB: begin
                dec_opcode = 8'hB0;
                dec_b      = {{(WIDTH-8){imm8[7]}}, imm8};
                dec_psr    = 1'b1;
            end
            4'h6, 4'h4: begin
                dec_opcode = {op, 4'h0};
                dec_b      = {{(WIDTH-8){1'b0}}, imm8};
                dec_wb     = 1'b1;
                dec_psr    = 1'b1;
            end
            4'hC: begin
                dec_opcode = 8'h0C;
                dec_b      = {{(WIDTH-8){1'b0}}, imm8};
                dec_psr    = 1'b1;
            end
            default: dec_legal = 1'b0;
        endcase
        if (!dec_legal) begin
            dec_opcode = '0;
            dec_wb     = 1'b0;
            dec_psr    = 1'b0;
        end
    end

    // Sequencer; done/illegal go high on entry to WB so they pulse for exactly the WB cycle.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state        <= IDLE;
            instr_q      <= '0;
            psr          <= '0;
            alu_opcode   <= '0;
            alu_a        <= '0;
            alu_b        <= '0;
            alu_carry_in <= 1'b0;
            done         <= 1'b0;
            illegal      <= 1'b0;
            result       <= '0;
            flag_q       <= '0;
            wb_en        <= 1'b0;
            psr_en       <= 1'b0;
            illegal_q    <= 1'b0;
            for (int i = 0; i < NREGS; i++) begin
                regs[i] <= '0;
            end
        end else begin
            done    <= 1'b0;
            illegal <= 1'b0;
            case (state)
                IDLE: begin
                    if (instr_valid) begin
                        instr_q <= instr;
                        state   <= DECODE;
                    end
                end
                DECODE: begin
                    alu_opcode   <= dec_opcode;
                    alu_a        <= regs[rdest];
                    alu_b        <= dec_b;
                    alu_carry_in <= psr[3];
                    wb_en        <= dec_wb;
                    psr_en       <= dec_psr;
                    illegal_q    <= !dec_legal;
                    state        <= EXEC;
                end
                EXEC: begin
                    result  <= alu_c;
                    flag_q  <= alu_flags;
                    done    <= !illegal_q;
                    illegal <= illegal_q;
                    state   <= WB;
                end
                WB: begin
                    if (wb_en) begin
                        regs[rdest] <= result;
                    end
                    if (psr_en) begin
                        psr <= flag_q;
                    end
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Bench for alu_issue_ctrl: a behavioural ALU closes the loop, and a register/PSR
// model derived from the decode rules predicts every retirement.
module tb_alu_issue_ctrl;

    logic        clk;
    logic        reset_n;
    logic        instr_valid;
    logic        instr_ready;
    logic [15:0] instr;
    logic [7:0]  alu_opcode;
    logic [15:0] alu_a;
    logic [15:0] alu_b;
    logic        alu_carry_in;
    logic [15:0] alu_c;
    logic [4:0]  alu_flags;
    logic [4:0]  psr;
    logic        done;
    logic        illegal;
    logic [3:0]  dbg_addr;
    logic [15:0] dbg_data;

    int total = 0;
    int bad   = 0;

    logic [15:0] mregs [16];
    logic [4:0]  mpsr;

    typedef struct packed {
        logic        legal;
        logic [7:0]  opc;
        logic [15:0] b;
        logic        wb;
        logic        pf;
    } dec_t;

    alu_issue_ctrl dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .instr_valid  (instr_valid),
        .instr_ready  (instr_ready),
        .instr        (instr),
        .alu_opcode   (alu_opcode),
        .alu_a        (alu_a),
        .alu_b        (alu_b),
        .alu_carry_in (alu_carry_in),
        .alu_c        (alu_c),
        .alu_flags    (alu_flags),
        .psr          (psr),
        .done         (done),
        .illegal      (illegal),
        .dbg_addr     (dbg_addr),
        .dbg_data     (dbg_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural ALU: returns {Z,C,O,L,N, result}.
    function automatic logic [20:0] alu_model(input logic [7:0] opc, input logic [15:0] a,
                                              input logic [15:0] b, input logic cin);
        logic [16:0] s;
        logic [15:0] c;
        logic cy, o, l, n;
        s  = '0;
        c  = '0;
        cy = 1'b0;
        o  = 1'b0;
        l  = (a < b);
        n  = ($signed(a) < $signed(b));
        case (opc)
            8'h01: c = a & b;
            8'h02: c = a | b;
            8'h03: c = a ^ b;
            8'h0F: c = ~a;
            8'h05, 8'h06, 8'h50, 8'h60, 8'h04, 8'h07, 8'h70, 8'h40: begin
                s = {1'b0, a} + {1'b0, b};
                if (opc inside {8'h04, 8'h07, 8'h70, 8'h40}) s = s + {16'h0, cin};
                c  = s[15:0];
                cy = s[16];
                o  = (a[15] == b[15]) && (c[15] != a[15]);
            end
            8'h09, 8'h90, 8'h08, 8'h0B, 8'hB0, 8'h0C: begin
                s  = {1'b0, a} - {1'b0, b};
                c  = s[15:0];
                cy = s[16];
                o  = (a[15] != b[15]) && (c[15] != a[15]);
            end
            8'h80, 8'h84: c = a << b[3:0];
            8'h81, 8'h85: c = a >> b[3:0];
            8'h86: c = a <<< b[3:0];
            8'h87: c = $unsigned($signed(a) >>> b[3:0]);
            default: c = '0;
        endcase
        return {(c == 16'h0), cy, o, l, n, c};
    endfunction

    assign {alu_flags, alu_c} = alu_model(alu_opcode, alu_a, alu_b, alu_carry_in);

    // Expected decode straight from the instruction-set table.
    function automatic dec_t ref_decode(input logic [15:0] ins, input logic [15:0] rsval);
        dec_t d;
        logic [3:0] op;
        logic [3:0] x;
        op = ins[15:12];
        x  = ins[7:4];
        d  = '0;
        d.legal = 1'b1;
        if (op == 4'h0 && x inside {4'h1, 4'h2, 4'h3, 4'hF}) begin
            d.opc = {op, x}; d.b = rsval; d.wb = 1'b1;
        end else if (op == 4'h0 && x inside {4'h4, 4'h5, 4'h6, 4'h7, 4'h9}) begin
            d.opc = {op, x}; d.b = rsval; d.wb = 1'b1; d.pf = 1'b1;
        end else if (op == 4'h0 && x inside {4'h8, 4'hB}) begin
            d.opc = {op, x}; d.b = rsval; d.pf = 1'b1;
        end else if (op == 4'h8 && x inside {4'h4, 4'h5, 4'h6, 4'h7}) begin
            d.opc = {op, x}; d.b = rsval; d.wb = 1'b1;
        end else if (op == 4'h8 && x inside {4'h0, 4'h1}) begin
            d.opc = {op, x}; d.b = {12'h0, ins[3:0]}; d.wb = 1'b1;
        end else if (op inside {4'h5, 4'h9, 4'h7}) begin
            d.opc = {op, 4'h0}; d.b = {{8{ins[7]}}, ins[7:0]}; d.wb = 1'b1; d.pf = 1'b1;
        end else if (op == 4'hB) begin
            d.opc = 8'hB0; d.b = {{8{ins[7]}}, ins[7:0]}; d.pf = 1'b1;
        end else if (op inside {4'h6, 4'h4}) begin
            d.opc = {op, 4'h0}; d.b = {8'h0, ins[7:0]}; d.wb = 1'b1; d.pf = 1'b1;
        end else if (op == 4'hC) begin
            d.opc = 8'h0C; d.b = {8'h0, ins[7:0]}; d.pf = 1'b1;
        end else begin
            d.legal = 1'b0;
        end
        return d;
    endfunction

    function automatic logic [15:0] rand_instr();
        logic [15:0] r;
        int k;
        r = 16'($urandom);
        k = int'($urandom_range(0, 9));
        if (k < 3) begin
            r[15:12] = 4'h0;
            case ($urandom_range(0, 10))
                0: r[7:4] = 4'h1;  1: r[7:4] = 4'h2;  2: r[7:4] = 4'h3;
                3: r[7:4] = 4'hF;  4: r[7:4] = 4'h4;  5: r[7:4] = 4'h5;
                6: r[7:4] = 4'h6;  7: r[7:4] = 4'h7;  8: r[7:4] = 4'h9;
                9: r[7:4] = 4'h8;  default: r[7:4] = 4'hB;
            endcase
        end else if (k < 5) begin
            r[15:12] = 4'h8;
            case ($urandom_range(0, 5))
                0: r[7:4] = 4'h0;  1: r[7:4] = 4'h1;  2: r[7:4] = 4'h4;
                3: r[7:4] = 4'h5;  4: r[7:4] = 4'h6;  default: r[7:4] = 4'h7;
            endcase
        end else if (k < 9) begin
            case ($urandom_range(0, 6))
                0: r[15:12] = 4'h5;  1: r[15:12] = 4'h9;  2: r[15:12] = 4'h7;
                3: r[15:12] = 4'hB;  4: r[15:12] = 4'h6;  5: r[15:12] = 4'h4;
                default: r[15:12] = 4'hC;
            endcase
        end
        return r;
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        assert (act === exp) else begin
            bad++;
            $error("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic checkReg(input logic [3:0] idx);
        dbg_addr = idx;
        #1;
        checkOutput($sformatf("reg%0d", idx), {16'h0, dbg_data}, {16'h0, mregs[idx]});
    endtask

    // Issues one instruction starting from an IDLE cycle and checks it through retirement.
    task automatic applyStimulus(input logic [15:0] ins, input bit hold_valid);
        dec_t d;
        logic [15:0] ea;
        logic [20:0] r;
        logic [3:0] rd;
        rd = ins[11:8];
        d  = ref_decode(ins, mregs[ins[3:0]]);
        ea = mregs[rd];
        r  = alu_model(d.opc, ea, d.b, mpsr[3]);

        checkOutput("ready_idle", {31'h0, instr_ready}, 32'h1);
        instr       = ins;
        instr_valid = 1'b1;
        @(posedge clk); #1;
        if (hold_valid) instr = 16'($urandom);
        else instr_valid = 1'b0;
        checkOutput("ready_decode", {31'h0, instr_ready}, 32'h0);

        @(posedge clk); #1;
        checkOutput("ready_exec", {31'h0, instr_ready}, 32'h0);
        checkOutput("alu_opcode", {24'h0, alu_opcode}, {24'h0, d.opc});
        checkOutput("alu_a", {16'h0, alu_a}, {16'h0, ea});
        checkOutput("alu_carry_in", {31'h0, alu_carry_in}, {31'h0, mpsr[3]});
        if (d.legal) checkOutput("alu_b", {16'h0, alu_b}, {16'h0, d.b});
        checkOutput("done_exec", {31'h0, done}, 32'h0);

        @(posedge clk); #1;
        checkOutput("ready_wb", {31'h0, instr_ready}, 32'h0);
        checkOutput("done_wb", {31'h0, done}, {31'h0, d.legal});
        checkOutput("illegal_wb", {31'h0, illegal}, {31'h0, !d.legal});
        if (d.wb) mregs[rd] = r[15:0];
        if (d.pf) mpsr = r[20:16];

        @(posedge clk); #1;
        instr_valid = 1'b0;
        checkOutput("ready_after", {31'h0, instr_ready}, 32'h1);
        checkOutput("done_after", {31'h0, done}, 32'h0);
        checkOutput("illegal_after", {31'h0, illegal}, 32'h0);
        checkOutput("psr", {27'h0, psr}, {27'h0, mpsr});
        checkReg(rd);
        checkReg(4'($urandom));
    endtask

    task automatic modelReset();
        for (int i = 0; i < 16; i++) mregs[i] = 16'h0;
        mpsr = 5'h0;
    endtask

    initial begin
        reset_n     = 1'b0;
        instr_valid = 1'b0;
        instr       = 16'h0;
        dbg_addr    = 4'h0;
        modelReset();
        repeat (2) @(posedge clk);
        #1;
        checkOutput("rst_ready", {31'h0, instr_ready}, 32'h1);
        checkOutput("rst_done", {31'h0, done}, 32'h0);
        checkOutput("rst_illegal", {31'h0, illegal}, 32'h0);
        checkOutput("rst_psr", {27'h0, psr}, 32'h0);
        checkOutput("rst_alu", {alu_opcode, alu_a, 7'h0, alu_carry_in}, 32'h0);
        checkOutput("rst_alu_b", {16'h0, alu_b}, 32'h0);
        reset_n = 1'b1;
        @(posedge clk); #1;

        // Directed scenarios
        applyStimulus(16'h517F, 1'b0);
        checkOutput("r1_7f", {16'h0, mregs[1]}, 32'h007F);
        applyStimulus(16'h52FF, 1'b0);
        applyStimulus(16'h63FF, 1'b0);
        checkOutput("r2_sext", {16'h0, mregs[2]}, 32'hFFFF);
        checkOutput("r3_zext", {16'h0, mregs[3]}, 32'h00FF);
        applyStimulus(16'h5440, 1'b0);
        applyStimulus(16'h8409, 1'b0);
        checkOutput("r4_lshi", {16'h0, mregs[4]}, 32'h8000);
        applyStimulus(16'h0454, 1'b0);
        checkOutput("r4_add", {16'h0, mregs[4]}, 32'h0000);
        checkOutput("psr_zco", {29'h0, mpsr[4:2]}, 32'h7);
        applyStimulus(16'h01B2, 1'b0);
        applyStimulus(16'hF000, 1'b1);
        @(posedge clk); #1;
        checkOutput("one_accept", {31'h0, instr_ready}, 32'h1);

        // Random traffic, sometimes holding instr_valid while busy
        for (int n = 0; n < 80; n++) begin
            applyStimulus(rand_instr(), 1'($urandom));
        end

        // Reset during EXEC aborts the instruction
        instr       = 16'h5501;
        instr_valid = 1'b1;
        @(posedge clk); #1;
        instr_valid = 1'b0;
        @(posedge clk); #1;
        reset_n = 1'b0;
        @(posedge clk); #1;
        reset_n = 1'b1;
        modelReset();
        checkOutput("abort_ready", {31'h0, instr_ready}, 32'h1);
        checkOutput("abort_done", {31'h0, done}, 32'h0);
        checkOutput("abort_psr", {27'h0, psr}, 32'h0);
        for (int i = 0; i < 16; i++) checkReg(4'(i));
        @(posedge clk); #1;
        checkOutput("abort_done2", {31'h0, done}, 32'h0);
        checkReg(4'h5);

        for (int n = 0; n < 20; n++) begin
            applyStimulus(rand_instr(), 1'b0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
